nios2_switch_scanner: RTL and testbench
=======================================

// Module: nios2_switch_scanner
// PURPOSE
//  Avalon-MM slave controller for the board slide switches. Sits between raw in_port pins and the Nios II data bus.
//  - Synchronises and debounces every switch bit.
//  - Captures rising/falling edges into a sticky register, with a per-bit interrupt mask.
//  - Software reads the stable switch state instead of sampling raw, bouncing pins.
// PARAMETERS
//  WIDTH         8         number of switch inputs
//  STABLE_TICKS  4         consecutive equal samples required to accept a new level (2..15)
//  DIV_RESET     16'd50000 reset value of the sample-tick divider (1 ms at 50 MHz)
// PORTS
//  clk        in   1      system clock; only clock domain
//  reset_n    in   1      asynchronous, active-low reset
//  address    in   2      register select
//  chipselect in   1      slave select
//  write_n    in   1      active-low write strobe (qualified by chipselect)
//  writedata  in   32     write data
//  in_port    in   WIDTH  raw asynchronous switch pins
//  readdata   out  32     registered read data, zero-extended
//  irq        out  1      level interrupt (present only with macro, see CONFIGURATION)
// BEHAVIOUR
//  Reset values: readdata=0, irq=0, sync flops=0, debounced state=0, edge_cap=0, irq_mask=0, div=DIV_RESET,
//    prescaler=0, all bit FSMs in STABLE with count=0.
//  Register map (readdata is registered: value appears 1 cycle after address is presented; read every cycle,
//    independent of chipselect):
//    0 DATA    RO  debounced state [WIDTH-1:0]
//    1 DIV     RW  [15:0] sample divider
//    2 MASK    RW  [WIDTH-1:0] interrupt enable
//    3 EDGE    RW1C [WIDTH-1:0] sticky edge capture
//  Writes take effect on the clk edge where chipselect=1 and write_n=0.
//  Input path: 2-flop synchroniser per bit. Synchronised value is valid 2 cycles after a pin change.
//  Prescaler:
//    - counts 0..DIV. tick=1 for one cycle when count==DIV, then count returns to 0.
//    - DIV=0 gives a tick every cycle.
//    - A write to DIV clears the prescaler in the same cycle; the next tick comes DIV+1 cycles later.
//  Per-bit FSM, advances only on tick:
//    STABLE  sync==deb: count=0, stay. sync!=deb: count=1 -> PENDING.
//    PENDING sync==deb (bounce): count=0 -> STABLE.
//            sync!=deb and count==STABLE_TICKS-1: deb<=sync, pulse edge, count=0 -> STABLE.
//            otherwise count++.
//  Latency from a clean pin change to DATA update: 2 cycles + STABLE_TICKS ticks (one tick of phase uncertainty).
//  EDGE:
//    - edge pulse sets the bit; writing 1 clears it.
//    - Set and clear on the same cycle: set wins.
//    - Both edge directions are captured.
//  Reset mid-debounce: all state is discarded. Immediately after reset deb=0, so any switch held high
//    re-debounces and sets EDGE once.
//  Writes to DATA are ignored. Unused upper readdata bits are 0.
// CONFIGURATION
//  NIOS2_SWITCH_SCANNER_IRQ_EN
//    defined: irq port exists; irq is registered, irq <= |(edge_cap & irq_mask), asserts 1 cycle after
//      EDGE/MASK change. MASK register is read/write.
//    undefined: irq port and mask logic are removed; MASK reads 0 and writes are ignored.
// STRUCTURE
//  Package nios2_switch_scanner_pkg:
//    - register address constants ADDR_DATA/ADDR_DIV/ADDR_MASK/ADDR_EDGE
//    - DIV_W=16
//    - bit-FSM state enum {ST_STABLE, ST_PENDING}
//    - CNT_W=4
//  Sub-module nios2_switch_debounce_bit: synchroniser, FSM and counter for one bit. Inputs tick and raw pin;
//    outputs deb and edge pulse. Generated WIDTH times.
//  Top level holds the prescaler, register file, read mux and irq.
// TESTING
//  1 Reset, read all 4 addresses -> DATA=0, DIV=50000, MASK=0, EDGE=0, irq=0.
//  2 DIV=3. in_port[0] 0->1 held -> DATA=0x01 after 2 cycles + 4 ticks (16..20 cycles); EDGE=0x01.
//  3 DIV=3. in_port[1] pulses high for 2 ticks, then low -> DATA stays 0x00, EDGE stays 0x00.
//  4 MASK=0x01, EDGE[0] set -> irq=1. Write EDGE=0x01 -> irq=0 next cycle.
//    Repeat with the clear write coinciding with a new edge pulse -> EDGE[0] stays 1.
//  5 DIV=0, toggle all 8 switches to 0xA5 -> DATA=0xA5 after 6 cycles, EDGE=0xA5.
//    Write DIV=100 mid-PENDING -> next tick arrives 101 cycles after the write.
//  6 Assert reset_n=0 mid-PENDING with in_port=0xFF, release -> all registers at reset values, then DATA=0xFF
//    after full debounce, EDGE=0xFF.

Source files
------------

// File: rtl/nios2_switch_scanner_pkg.sv
// nios2_switch_scanner_pkg
//   Shared constants and types for the slide-switch scanner.
//   - ADDR_*      : Avalon-MM register addresses (DATA, DIV, MASK, EDGE)
//   - DIV_W       : width of the sample-tick divider
//   - CNT_W       : width of the per-bit stability counter
//   - bit_state_t : per-bit debounce FSM states
//   Related build macro: NIOS2_SWITCH_SCANNER_IRQ_EN (used by the top level).
package nios2_switch_scanner_pkg;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_DIV  = 2'd1;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   localparam int unsigned DIV_W = 16;
   localparam int unsigned CNT_W = 4;

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } bit_state_t;

endpackage

// File: rtl/nios2_switch_debounce_bit.sv
// nios2_switch_debounce_bit
//   Two-flop synchroniser plus tick-driven debounce FSM for one switch.
//   A new level is accepted after STABLE_TICKS consecutive ticks that all
//   see the synchronised pin differing from the debounced level.
// Ports:
//   clk        in  system clock
//   reset_n    in  asynchronous active-low reset
//   tick       in  sample strike from the shared prescaler
//   pin        in  raw asynchronous switch pin
//   deb        out debounced level
//   edge_pulse out one-cycle pulse when deb changes (either direction)
module nios2_switch_debounce_bit
   import nios2_switch_scanner_pkg::*;
#(
   parameter int unsigned STABLE_TICKS = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tick,
   input  logic pin,
   output logic deb,
   output logic edge_pulse
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_TICKS - 1);

   logic             sync_meta;
   logic             sync;
   bit_state_t       state;
   bit_state_t       state_nxt;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic             deb_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
         state     <= ST_STABLE;
         count     <= '0;
         deb       <= 1'b0;
      end else begin
         sync_meta <= pin;
         sync      <= sync_meta;
         state     <= state_nxt;
         count     <= count_nxt;
         deb       <= deb_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      deb_nxt    = deb;
      edge_pulse = 1'b0;
      if (tick) begin
         case (state)
            ST_STABLE: begin
               if (sync != deb) begin
                  count_nxt = CNT_W'(1);
                  state_nxt = ST_PENDING;
               end else begin
                  count_nxt = '0;
               end
            end
            ST_PENDING: begin
               if (sync == deb) begin
                  // bounce back to the old level: start over
                  count_nxt = '0;
                  state_nxt = ST_STABLE;
               end else if (count == LAST) begin
                  deb_nxt    = sync;
                  edge_pulse = 1'b1;
                  count_nxt  = '0;
                  state_nxt  = ST_STABLE;
               end else begin
                  count_nxt = count + 1'b1;
               end
            end
            default: begin
               count_nxt = '0;
               state_nxt = ST_STABLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/nios2_switch_scanner.sv
// nios2_switch_scanner
//   Avalon-MM slave for board slide switches: synchronises and debounces each
//   pin, captures both edge directions into a sticky register, and optionally
//   raises a masked level interrupt.
//   Build macro NIOS2_SWITCH_SCANNER_IRQ_EN: when defined, the irq port and the
//   MASK register exist; otherwise MASK reads 0 and ignores writes.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   address    in   register select (0 DATA, 1 DIV, 2 MASK, 3 EDGE)
//   chipselect in   slave select
//   write_n    in   active-low write strobe
//   writedata  in   write data
//   in_port    in   raw switch pins
//   readdata   out  registered, zero-extended read data (updated every cycle)
//   irq        out  level interrupt (only with NIOS2_SWITCH_SCANNER_IRQ_EN)
module nios2_switch_scanner
   import nios2_switch_scanner_pkg::*;
#(
   parameter int unsigned      WIDTH        = 8,
   parameter int unsigned      STABLE_TICKS = 4,
   parameter logic [DIV_W-1:0] DIV_RESET    = 16'd50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata
`ifdef NIOS2_SWITCH_SCANNER_IRQ_EN
  ,output logic             irq
`endif
);

   logic             wr_en;
   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] presc;
   logic             tick;
   logic [WIDTH-1:0] deb_vec;
   logic [WIDTH-1:0] pulse_vec;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] mask_rd;
   logic [31:0]      rd_mux;
   logic             unused_wdata;

   assign wr_en        = chipselect && !write_n;
   assign tick         = (presc == div);
   assign unused_wdata = ^writedata[31:DIV_W];

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      nios2_switch_debounce_bit #(
         .STABLE_TICKS (STABLE_TICKS)
      ) u_bit (
         .clk        (clk),
         .reset_n    (reset_n),
         .tick       (tick),
         .pin        (in_port[i]),
         .deb        (deb_vec[i]),
         .edge_pulse (pulse_vec[i])
      );
   end

   // A DIV write restarts the prescaler so the next tick is DIV+1 cycles out.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div   <= DIV_RESET;
         presc <= '0;
      end else begin
         if (wr_en && address == ADDR_DIV) begin
            div   <= writedata[DIV_W-1:0];
            presc <= '0;
         end else if (tick) begin
            presc <= '0;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

   // Set has priority over a simultaneous write-one-to-clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_cap <= '0;
      end else if (wr_en && address == ADDR_EDGE) begin
         edge_cap <= (edge_cap & ~writedata[WIDTH-1:0]) | pulse_vec;
      end else begin
         edge_cap <= edge_cap | pulse_vec;
      end
   end

`ifdef NIOS2_SWITCH_SCANNER_IRQ_EN
   logic [WIDTH-1:0] irq_mask;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask <= '0;
         irq      <= 1'b0;
      end else begin
         if (wr_en && address == ADDR_MASK) begin
            irq_mask <= writedata[WIDTH-1:0];
         end
         irq <= |(edge_cap & irq_mask);
      end
   end

   assign mask_rd = irq_mask;
`else
   assign mask_rd = '0;
`endif

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA: rd_mux[WIDTH-1:0] = deb_vec;
         ADDR_DIV:  rd_mux[DIV_W-1:0] = div;
         ADDR_MASK: rd_mux[WIDTH-1:0] = mask_rd;
         ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_cap;
         default:   rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_nios2_switch_scanner.sv
// tb_nios2_switch_scanner
//   Directed self-checking bench for nios2_switch_scanner (WIDTH=8,
//   STABLE_TICKS=4). irq checks are compiled only with
//   NIOS2_SWITCH_SCANNER_IRQ_EN; otherwise MASK is expected to read 0.
module tb_nios2_switch_scanner;
   import nios2_switch_scanner_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [7:0]  in_port;
   logic [31:0] readdata;
`ifdef NIOS2_SWITCH_SCANNER_IRQ_EN
   logic        irq;
`endif

   int tests  = 0;
   int failed = 0;

   nios2_switch_scanner #(
      .WIDTH        (8),
      .STABLE_TICKS (4),
      .DIV_RESET    (16'd50000)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata)
`ifdef NIOS2_SWITCH_SCANNER_IRQ_EN
     ,.irq        (irq)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Called at #1 after a rising edge; returns at #1 after the write edge.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      address = a;
      @(posedge clk); #1;
      d = readdata;
   endtask

   // Polls DATA every cycle; n is the number of edges until it matches.
   task automatic wait_data(input logic [31:0] exp, input int limit, output int n);
      address = ADDR_DATA;
      n = 0;
      while (n < limit) begin
         @(posedge clk); #1;
         n++;
         if (readdata === exp) break;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      int n;

      // ---- 1: reset values
      reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
      writedata = '0; in_port = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("t1_readdata_in_reset", readdata, 32'h0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      rd(ADDR_DATA, v); check("t1_data", v, 32'h0);
      rd(ADDR_DIV,  v); check("t1_div",  v, 32'd50000);
      rd(ADDR_MASK, v); check("t1_mask", v, 32'h0);
      rd(ADDR_EDGE, v); check("t1_edge", v, 32'h0);
`ifdef NIOS2_SWITCH_SCANNER_IRQ_EN
      check("t1_irq", {31'b0, irq}, 32'h0);
`endif

      // ---- 2: clean rising edge on bit 0 with DIV=3 (tick every 4 cycles)
      wr(ADDR_DIV, 32'd3);
      rd(ADDR_DIV, v); check("t2_div", v, 32'd3);
      address = ADDR_DATA;
      in_port = 8'h01;
      wait_data(32'h01, 40, n);
      check("t2_data", readdata, 32'h01);
      check("t2_latency_16_20", {31'b0, (n >= 16 && n <= 20)}, 32'h1);
      rd(ADDR_EDGE, v); check("t2_edge", v, 32'h01);

      // ---- 3: short glitch on bit 1 is rejected
      wr(ADDR_EDGE, 32'h01);
      rd(ADDR_EDGE, v); check("t3_edge_cleared", v, 32'h0);
      in_port = 8'h03;
      repeat (8) @(posedge clk);
      #1;
      in_port = 8'h01;
      repeat (40) @(posedge clk);
      #1;
      rd(ADDR_DATA, v); check("t3_data", v, 32'h01);
      rd(ADDR_EDGE, v); check("t3_edge", v, 32'h0);

      // ---- 4: mask / irq and EDGE set-over-clear
`ifdef NIOS2_SWITCH_SCANNER_IRQ_EN
      wr(ADDR_MASK, 32'h01);
      rd(ADDR_MASK, v); check("t4_mask", v, 32'h01);
      check("t4_irq_idle", {31'b0, irq}, 32'h0);
`else
      wr(ADDR_MASK, 32'hFF);
      rd(ADDR_MASK, v); check("t4_mask_absent", v, 32'h0);
`endif
      in_port = 8'h00;
      wait_data(32'h00, 40, n);
      check("t4_data_fall", readdata, 32'h0);
      rd(ADDR_EDGE, v); check("t4_edge_fall", v, 32'h01);
`ifdef NIOS2_SWITCH_SCANNER_IRQ_EN
      check("t4_irq_set", {31'b0, irq}, 32'h1);
`endif
      wr(ADDR_EDGE, 32'h01);
`ifdef NIOS2_SWITCH_SCANNER_IRQ_EN
      check("t4_irq_lag", {31'b0, irq}, 32'h1);
      @(posedge clk); #1;
      check("t4_irq_clear", {31'b0, irq}, 32'h0);
`endif
      rd(ADDR_EDGE, v); check("t4_edge_cleared", v, 32'h0);
      // DIV=0: pin change after E0 -> edge pulse lands on E6; clear at E6.
      wr(ADDR_DIV, 32'd0);
      in_port = 8'h01;
      repeat (5) @(posedge clk);
      #1;
      wr(ADDR_EDGE, 32'h01);
      rd(ADDR_EDGE, v); check("t4_set_wins", v, 32'h01);
      rd(ADDR_DATA, v); check("t4_data_rise", v, 32'h01);

      // ---- 5: all bits with DIV=0, then DIV rewrite mid-PENDING
      in_port = 8'h00;
      repeat (10) @(posedge clk);
      #1;
      wr(ADDR_EDGE, 32'hFF);
      rd(ADDR_EDGE, v); check("t5_edge_cleared", v, 32'h0);
      address = ADDR_DATA;
      in_port = 8'hA5;
      repeat (6) @(posedge clk);
      #1;
      check("t5_data_e6_old", readdata, 32'h00);
      @(posedge clk); #1;
      check("t5_data_e7", readdata, 32'hA5);
      rd(ADDR_EDGE, v); check("t5_edge", v, 32'hA5);
      // Pins drop after E0; bits enter PENDING at E3 where DIV=100 lands.
      // Ticks then at W+101, W+202, W+303; DATA visible on W+304.
      in_port = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      wr(ADDR_DIV, 32'd100);
      address = ADDR_DATA;
      n = 0;
      while (n < 400) begin
         @(posedge clk); #1;
         n++;
         if (readdata === 32'h0) break;
      end
      check("t5_div_restart_latency", n, 32'd304);
      rd(ADDR_DIV, v); check("t5_div", v, 32'd100);

      // ---- 6: reset mid-PENDING discards state
      wr(ADDR_DIV, 32'd3);
      in_port = 8'hFF;
      repeat (10) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("t6_readdata_async", readdata, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
`ifdef NIOS2_SWITCH_SCANNER_IRQ_EN
      check("t6_irq", {31'b0, irq}, 32'h0);
`endif
      rd(ADDR_DATA, v); check("t6_data", v, 32'h0);
      rd(ADDR_DIV,  v); check("t6_div",  v, 32'd50000);
      rd(ADDR_MASK, v); check("t6_mask", v, 32'h0);
      rd(ADDR_EDGE, v); check("t6_edge", v, 32'h0);
      wr(ADDR_DIV, 32'd3);
      wait_data(32'hFF, 40, n);
      check("t6_data_redebounce", readdata, 32'hFF);
      rd(ADDR_EDGE, v); check("t6_edge_redebounce", v, 32'hFF);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
